lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 480000, meaning number of i_clk cycles the LCD reset is held asserted.
REQ-002 Parameter WAKE_CYCLES, default 5760000, meaning number of i_clk cycles to wait after reset release before any write.
REQ-003 Parameter WR_LOW, default 2, range 1..15, meaning number of i_clk cycles o_lcd_wr is low per byte.
REQ-004 Parameter WR_HIGH, default 2, range 1..15, meaning number of i_clk cycles o_lcd_wr is high after each byte.
REQ-005 Ports, one clock; reset is asynchronous and active-low:
- i_clk  in  1  sole clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_soft_reset  in  1  one-cycle request to rerun the LCD reset sequence.
- i_cmd_valid, i_cmd_rs, i_cmd_data  in  1/1/8  host byte stream; rs=0 command, rs=1 parameter.
- o_cmd_ready  out  1  host byte accepted when valid and ready.
- i_pix_valid, i_pix_data, i_pix_last  in  1/8/1  pixel byte stream; last marks the final byte of a frame.
- o_pix_ready  out  1  pixel byte accepted when valid and ready.
- i_lcd_fmark  in  1  asynchronous tearing-effect input from the panel.
- o_lcd_wr, o_lcd_rs, o_lcd_data  out  1/1/8  8080 write bus.
- o_lcd_reset_inverted, o_lcd_cs_inverted  out  1/1  1 = drive the open-drain pin low.
- o_init_done  out  1  high while the sequencer is past the wake wait.
- o_fmark_missed  out  1  one-cycle pulse when a frame slot is lost.

Function
REQ-006 FSM states: RST_HOLD, RST_WAKE, IDLE, WR_LO, WR_HI.
REQ-007 RST_HOLD: o_lcd_reset_inverted=1 for RESET_CYCLES cycles, then go to RST_WAKE.
REQ-008 RST_WAKE: o_lcd_reset_inverted=0 for WAKE_CYCLES cycles, then go to IDLE.
REQ-009 o_init_done and o_lcd_cs_inverted are 1 in IDLE, WR_LO and WR_HI, and 0 in the reset states.
REQ-010 o_cmd_ready and o_pix_ready are 0 outside IDLE, and never both 1 in the same cycle.
REQ-011 Grant priority in IDLE:
- inside a pixel burst, only the pixel port is ready;
- otherwise the command port is ready;
- if i_cmd_valid=0 and frame_pending=1, the pixel port is ready.
REQ-012 A pixel burst begins when the first pixel byte is accepted with frame_pending=1; that same acceptance clears frame_pending.
REQ-013 A pixel burst ends on acceptance of a byte with i_pix_last=1. Commands are blocked for the whole burst.
REQ-014 On any acceptance, the byte and rs are latched on that edge (rs=1 for pixels) and the FSM enters WR_LO the next cycle.
REQ-015 WR_LO holds o_lcd_wr=0 for WR_LOW cycles. WR_HI holds o_lcd_wr=1 for WR_HIGH cycles, then returns to IDLE.
REQ-016 o_lcd_data and o_lcd_rs stay stable from WR_LO entry until the next acceptance.
REQ-017 Peak throughput is one byte per 1+WR_LOW+WR_HIGH cycles (5 at defaults).
REQ-018 i_lcd_fmark passes through a 2-FF synchronizer; a rising edge sets frame_pending.
REQ-019 A rising edge while frame_pending=1 or during a burst pulses o_fmark_missed for one cycle. frame_pending stays or becomes 1.
REQ-020 A rising edge coincident with a burst-start acceptance: the acceptance clears frame_pending and the edge sets it again, with no miss pulse.
REQ-021 i_soft_reset is honoured only in IDLE. It enters RST_HOLD and clears frame_pending and burst state. It is ignored in all other states.
REQ-022 Delay counters are sized with $clog2 of the largest parameter and saturate-free; they reload on each state entry.

Reset
REQ-023 While i_reset_n=0, and immediately on its assertion:
- state=RST_HOLD with its counter cleared;
- o_lcd_reset_inverted=1, o_lcd_cs_inverted=0, o_lcd_wr=1, o_lcd_rs=0, o_lcd_data=0;
- both readies=0, o_init_done=0, o_fmark_missed=0;
- frame_pending=0, burst=0, synchronizer flops=0.
REQ-024 Reset asserted during a write cycle aborts the cycle at once; the byte is not retried.

Structure
REQ-025 Shared package lcd_pkg holds the state enum, default timing constants, and the rs encoding (CMD=0, DATA=1).
REQ-026 One sub-module, lcd_fmark_sync, implements the 2-FF synchronizer plus rising-edge pulse. All other logic stays flat in lcd_sequencer.

Verification
REQ-027 Bench with RESET_CYCLES=4, WAKE_CYCLES=6; release reset -> reset_inverted=1 for 4 cycles, 0 for 6, then o_init_done=1 and cs_inverted=1.
REQ-028 Command 0x2C with rs=0 held valid -> ready for one cycle, wr low 2 cycles then high 2, data=0x2C, rs=0; next acceptance 5 cycles later.
REQ-029 Pixel valid with no fmark -> o_pix_ready stays 0. Pulse fmark -> ready within 4 cycles; 3 bytes, last on the third, are all written with rs=1.
REQ-030 Command valid during a pixel burst -> command not accepted until the byte with i_pix_last=1 completes.
REQ-031 Two fmark edges with no pixel acceptance -> exactly one o_fmark_missed pulse and frame_pending=1.
REQ-032 Assert i_reset_n mid-WR_LO -> same cycle wr=1, reset_inverted=1, cs_inverted=0. i_soft_reset in IDLE -> full reset sequence reruns.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD sequencer: FSM state encoding, default
// panel timing and the 8080 register-select encoding.
package lcd_pkg;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        RST_WAKE = 3'd1,
        IDLE     = 3'd2,
        WR_LO    = 3'd3,
        WR_HI    = 3'd4
    } lcd_state_e;

    // Default timing, in clock cycles
    localparam int DEF_RESET_CYCLES = 480000;
    localparam int DEF_WAKE_CYCLES  = 5760000;
    localparam int DEF_WR_LOW       = 2;
    localparam int DEF_WR_HIGH      = 2;

    // Register-select encoding on the write bus
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Largest of four delays, used to size the shared delay counter
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_fmark_sync.sv
// Brings the panel's asynchronous tearing-effect signal into the clock domain
// and produces a one-cycle pulse on each synchronized rising edge.
module lcd_fmark_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_fmark,
    output logic o_rise
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Two metastability flops followed by one history flop for edge detection
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= i_fmark;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign o_rise = sync_q2 & ~sync_q3;

endmodule

// File: rtl/lcd_sequencer.sv
// 8080-style LCD write sequencer. Runs the panel reset/wake sequence, then
// arbitrates a host command stream and a frame-synchronized pixel stream onto
// the write bus, one byte per WR_LO/WR_HI strobe.
//
// Handshake: a byte is transferred on a rising clock edge where valid and
// ready are both 1; ready never depends on the transfer having happened,
// and valid/data must be held until that edge.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
    parameter int WR_LOW       = DEF_WR_LOW,
    parameter int WR_HIGH      = DEF_WR_HIGH
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_soft_reset,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    input  logic       i_pix_valid,
    input  logic [7:0] i_pix_data,
    input  logic       i_pix_last,
    output logic       o_pix_ready,
    input  logic       i_lcd_fmark,
    output logic       o_lcd_wr,
    output logic       o_lcd_rs,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_reset_inverted,
    output logic       o_lcd_cs_inverted,
    output logic       o_init_done,
    output logic       o_fmark_missed,
    output lcd_state_e o_dbg_state,
    output logic       o_dbg_frame_pending
);

    localparam int CNT_MAX = max_of4(RESET_CYCLES, WAKE_CYCLES, WR_LOW, WR_HIGH);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Last count value of each timed state
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST    = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOW_LAST  = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0] WR_HIGH_LAST = CNT_W'(WR_HIGH - 1);

    lcd_state_e       state_q;
    lcd_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_ready;
    logic             pix_ready;
    logic             soft_take;
    logic             cmd_acc;
    logic             pix_acc;
    logic             burst_start;
    logic             fm_rise;
    logic             pend_q;
    logic             burst_q;
    logic             missed_q;
    logic             rs_q;
    logic [7:0]       data_q;

    lcd_fmark_sync u_fmark_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_fmark   (i_lcd_fmark),
        .o_rise    (fm_rise)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= RST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and port grants; a soft reset in IDLE wins over any grant
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        soft_take = 1'b0;
        case (state_q)
            RST_HOLD: if (cnt_q == RESET_LAST) state_d = RST_WAKE;
            RST_WAKE: if (cnt_q == WAKE_LAST) state_d = IDLE;
            IDLE: begin
                if (i_soft_reset) begin
                    soft_take = 1'b1;
                    state_d   = RST_HOLD;
                end else begin
                    if (burst_q) begin
                        pix_ready = 1'b1;
                    end else if (!i_cmd_valid && pend_q) begin
                        pix_ready = 1'b1;
                    end else begin
                        cmd_ready = 1'b1;
                    end
                    if ((cmd_ready && i_cmd_valid) || (pix_ready && i_pix_valid)) begin
                        state_d = WR_LO;
                    end
                end
            end
            WR_LO: if (cnt_q == WR_LOW_LAST) state_d = WR_HI;
            WR_HI: if (cnt_q == WR_HIGH_LAST) state_d = IDLE;
            default: state_d = RST_HOLD;
        endcase
    end

    assign cmd_acc     = cmd_ready & i_cmd_valid;
    assign pix_acc     = pix_ready & i_pix_valid;
    assign burst_start = pix_acc & ~burst_q;

    // Delay counter restarts from zero on every state entry; parked in IDLE
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Latch the accepted byte; it stays on the bus until the next acceptance
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs_q   <= RS_CMD;
            data_q <= 8'h00;
        end else if (cmd_acc) begin
            rs_q   <= i_cmd_rs;
            data_q <= i_cmd_data;
        end else if (pix_acc) begin
            rs_q   <= RS_DATA;
            data_q <= i_pix_data;
        end
    end

    // Frame slot bookkeeping: pending frame, active burst and miss pulse.
    // An edge landing on the burst-start acceptance re-arms pending silently.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_q   <= 1'b0;
            burst_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            missed_q <= fm_rise & (burst_q | (pend_q & ~burst_start));
            if (soft_take) begin
                pend_q  <= 1'b0;
                burst_q <= 1'b0;
            end else begin
                if (fm_rise) begin
                    pend_q <= 1'b1;
                end else if (burst_start) begin
                    pend_q <= 1'b0;
                end
                if (pix_acc) begin
                    burst_q <= ~i_pix_last;
                end
            end
        end
    end

    assign o_cmd_ready          = cmd_ready;
    assign o_pix_ready          = pix_ready;
    assign o_lcd_wr             = (state_q != WR_LO);
    assign o_lcd_rs             = rs_q;
    assign o_lcd_data           = data_q;
    assign o_lcd_reset_inverted = (state_q == RST_HOLD);
    assign o_init_done          = (state_q == IDLE) || (state_q == WR_LO) || (state_q == WR_HI);
    assign o_lcd_cs_inverted    = o_init_done;
    assign o_fmark_missed       = missed_q;
    assign o_dbg_state          = state_q;
    assign o_dbg_frame_pending  = pend_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer with short reset/wake timing. Expected bus writes
// ({rs, data}) are queued by the scenarios in the order the arbitration
// rules dictate; a negedge monitor pops and compares on each write strobe.
module tb_lcd_sequencer;
    import lcd_pkg::*;

    localparam int RESET_CYCLES = 4;
    localparam int WAKE_CYCLES  = 6;
    localparam int WR_LOW       = 2;
    localparam int WR_HIGH      = 2;
    localparam int BYTE_PERIOD  = 1 + WR_LOW + WR_HIGH;
    localparam int SEQ_LEN      = RESET_CYCLES + WAKE_CYCLES;

    // ---------------- clock / reset / DUT ----------------
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       soft_reset = 1'b0;
    logic       cmd_valid  = 1'b0;
    logic       cmd_rs     = 1'b0;
    logic [7:0] cmd_data   = 8'h00;
    logic       pix_valid  = 1'b0;
    logic [7:0] pix_data   = 8'h00;
    logic       pix_last   = 1'b0;
    logic       fmark      = 1'b0;

    logic       cmd_ready;
    logic       pix_ready;
    logic       lcd_wr;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_reset_inv;
    logic       lcd_cs_inv;
    logic       init_done;
    logic       fmark_missed;
    lcd_state_e dbg_state;
    logic       dbg_pending;

    always #5 clk = ~clk;

    lcd_sequencer #(
        .RESET_CYCLES (RESET_CYCLES),
        .WAKE_CYCLES  (WAKE_CYCLES),
        .WR_LOW       (WR_LOW),
        .WR_HIGH      (WR_HIGH)
    ) dut (
        .i_clk                (clk),
        .i_reset_n            (rst_n),
        .i_soft_reset         (soft_reset),
        .i_cmd_valid          (cmd_valid),
        .i_cmd_rs             (cmd_rs),
        .i_cmd_data           (cmd_data),
        .o_cmd_ready          (cmd_ready),
        .i_pix_valid          (pix_valid),
        .i_pix_data           (pix_data),
        .i_pix_last           (pix_last),
        .o_pix_ready          (pix_ready),
        .i_lcd_fmark          (fmark),
        .o_lcd_wr             (lcd_wr),
        .o_lcd_rs             (lcd_rs),
        .o_lcd_data           (lcd_data),
        .o_lcd_reset_inverted (lcd_reset_inv),
        .o_lcd_cs_inverted    (lcd_cs_inv),
        .o_init_done          (init_done),
        .o_fmark_missed       (fmark_missed),
        .o_dbg_state          (dbg_state),
        .o_dbg_frame_pending  (dbg_pending)
    );

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    logic [7:0] pix_buf[$];
    logic [7:0] cbuf_data[$];
    logic       cbuf_rs[$];
    int         fall_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         miss_cnt = 0;
    logic       first_pix_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- monitor ----------------
    logic       prev_wr = 1'b1;
    logic       have_word = 1'b0;
    int         low_len = 0;
    logic [8:0] cur_word = 9'h0;

    // Compare every write strobe against the expected queue and watch bus timing
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_wr   = 1'b1;
            have_word = 1'b0;
            low_len   = 0;
        end else begin
            if (fmark_missed) miss_cnt++;
            check("ready_exclusive", int'(cmd_ready & pix_ready), 0);
            if (prev_wr && !lcd_wr) begin
                fall_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got rs=%0d data=0x%02h, required no write", lcd_rs, lcd_data);
                end else begin
                    check("write_word", int'({lcd_rs, lcd_data}), int'(exp_q.pop_front()));
                end
                cur_word  = {lcd_rs, lcd_data};
                have_word = 1'b1;
                low_len   = 1;
            end else begin
                if (!lcd_wr) low_len++;
                if (!prev_wr && lcd_wr) check("wr_low_cycles", low_len, WR_LOW);
                if (have_word) check("bus_stable", int'({lcd_rs, lcd_data}), int'(cur_word));
            end
            prev_wr = lcd_wr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic rs, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (cmd_ready) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        timeout_fail("cmd_handshake");
        cmd_valid = 1'b0;
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            logic done;
            done      = 1'b0;
            pix_valid = 1'b1;
            pix_data  = pix_buf[i];
            pix_last  = (i == n - 1);
            for (int k = 0; k < 400 && !done; k++) begin
                #1;
                if (pix_ready) done = 1'b1;
                @(negedge clk);
            end
            if (!done) begin
                timeout_fail("pix_handshake");
                pix_valid = 1'b0;
                pix_last  = 1'b0;
                return;
            end
            if (i == 0) first_pix_done = 1'b1;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic pulse_fmark();
        @(negedge clk);
        #2 fmark = 1'b1;
        repeat (3) @(negedge clk);
        fmark = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reset/wake profile, starting on the first cycle of RST_HOLD
    task automatic check_seq(input string tag);
        for (int i = 0; i <= SEQ_LEN; i++) begin
            logic [5:0] exp_v;
            #1;
            exp_v = {(i < RESET_CYCLES), (i >= SEQ_LEN), (i >= SEQ_LEN), 1'b1, (i >= SEQ_LEN), 1'b0};
            check(tag, int'({lcd_reset_inv, init_done, lcd_cs_inv, lcd_wr, cmd_ready, pix_ready}), int'(exp_v));
            if (i < SEQ_LEN) @(negedge clk);
        end
    endtask

    // One frame: optional fmark, npix pixel bytes, then nc commands that are
    // raised only once the burst has started and so must follow every pixel
    task automatic run_frame(input int npix, input int nc, input logic do_fmark);
        pix_buf.delete();
        cbuf_data.delete();
        cbuf_rs.delete();
        for (int i = 0; i < npix; i++) begin
            pix_buf.push_back(8'($urandom_range(0, 255)));
            exp_q.push_back({RS_DATA, pix_buf[i]});
        end
        for (int j = 0; j < nc; j++) begin
            cbuf_data.push_back(8'($urandom_range(0, 255)));
            cbuf_rs.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back({cbuf_rs[j], cbuf_data[j]});
        end
        if (do_fmark) pulse_fmark();
        first_pix_done = 1'b0;
        fork
            send_pixels(npix);
            begin
                for (int k = 0; k < 500 && !first_pix_done; k++) @(negedge clk);
                if (!first_pix_done) timeout_fail("burst_start");
                for (int j = 0; j < nc; j++) send_cmd(cbuf_rs[j], cbuf_data[j]);
            end
        join
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_q.size() != 0 || !lcd_wr); k++) @(negedge clk);
        repeat (BYTE_PERIOD) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int miss0;
        int lat;
        logic [7:0] r;

        // Reset state while held
        @(negedge clk);
        #1;
        check("reset_outputs",
              int'({lcd_reset_inv, lcd_cs_inv, lcd_wr, lcd_rs, lcd_data, cmd_ready, pix_ready, init_done, fmark_missed}),
              int'({1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset_pending", int'(dbg_pending), 0);

        // Power-up sequence
        @(negedge clk);
        rst_n = 1'b1;
        check_seq("powerup_seq");

        // Back-to-back commands: 0x2C then a random one, BYTE_PERIOD apart
        r = 8'($urandom_range(0, 255));
        exp_q.push_back({RS_CMD, 8'h2C});
        exp_q.push_back({RS_CMD, r});
        fall_q.delete();
        send_cmd(RS_CMD, 8'h2C);
        send_cmd(RS_CMD, r);
        for (int k = 0; k < 50 && fall_q.size() < 2; k++) @(negedge clk);
        if (fall_q.size() < 2) timeout_fail("cmd_pair_writes");
        else check("cmd_spacing", fall_q[1] - fall_q[0], BYTE_PERIOD);
        drain();

        // Pixels wait for fmark, then flow with rs=1
        pix_buf.delete();
        for (int i = 0; i < 3; i++) begin
            pix_buf.push_back(8'($urandom_range(0, 255)));
            exp_q.push_back({RS_DATA, pix_buf[i]});
        end
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = pix_buf[0];
        for (int k = 0; k < 12; k++) begin
            #1;
            check("pix_ready_no_fmark", int'(pix_ready), 0);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        #2 fmark = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            #1;
            if (pix_ready) lat = k;
        end
        check("fmark_to_ready_in_4", int'((lat >= 1) && (lat <= 4)), 1);
        fmark = 1'b0;
        @(negedge clk);
        send_pixels(3);
        drain();

        // Command raised during a burst must wait for the last pixel
        run_frame(4, 1, 1'b1);
        drain();

        // Two fmark edges with nothing consumed: one miss, still pending
        miss0 = miss_cnt;
        pulse_fmark();
        pulse_fmark();
        repeat (4) @(negedge clk);
        check("double_fmark_misses", miss_cnt - miss0, 1);
        check("double_fmark_pending", int'(dbg_pending), 1);
        run_frame(1, 0, 1'b0);
        drain();
        check("pending_consumed", int'(dbg_pending), 0);

        // Soft reset outside IDLE is ignored
        exp_q.push_back({RS_DATA, 8'hA5});
        send_cmd(RS_DATA, 8'hA5);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("soft_reset_ignored", int'({init_done, lcd_reset_inv}), int'(2'b10));
        drain();

        // Soft reset in IDLE reruns the sequence
        @(negedge clk);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        check_seq("soft_reset_seq");

        // Randomized traffic: lone commands, then frames with trailing commands
        miss0 = miss_cnt;
        for (int round = 0; round < 8; round++) begin
            int nlone;
            nlone = $urandom_range(0, 3);
            for (int j = 0; j < nlone; j++) begin
                logic       rrs;
                logic [7:0] rd;
                rrs = 1'($urandom_range(0, 1));
                rd  = 8'($urandom_range(0, 255));
                exp_q.push_back({rrs, rd});
                send_cmd(rrs, rd);
            end
            run_frame($urandom_range(1, 5), $urandom_range(0, 2), 1'b1);
            drain();
        end
        check("random_no_misses", miss_cnt - miss0, 0);

        // Hard reset in the middle of WR_LO aborts the write at once
        exp_q.push_back({RS_CMD, 8'h3C});
        send_cmd(RS_CMD, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs",
              int'({lcd_wr, lcd_reset_inv, lcd_cs_inv, init_done, cmd_ready, pix_ready, lcd_rs, lcd_data}),
              int'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        check("abort_state", int'(dbg_state), int'(RST_HOLD));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_seq("rerun_seq");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
